tag_sysid_probe: RTL and testbench

Avalon-MM read master that interrogates the system ID slave at boot or on request: it reads the ID word (word 0) and the build timestamp word (word 1), compares both against build-time expected values, and reports pass/fail. It sits beside the Nios II in the tag system. It lets the hardware flag a mismatched bitstream/software pairing, or a hung interconnect, without processor involvement.

---
 rtl/tag_sysid_pkg.sv | 27 ++
 rtl/tag_sysid_probe.sv | 175 +++++++++++++++++
 tb/tb_tag_sysid_probe.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_sysid_pkg.sv
// Shared definitions for the system ID probe: FSM states, sysid word
// addresses and the default build-time expected values.
package tag_sysid_pkg;

  // Probe FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Word addresses within the sysid slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Default values the bitstream is expected to report.
  localparam logic [31:0] DEF_EXPECTED_ID    = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TS    = 32'h606F_A015;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd255;

  // Full 32-bit inequality; no bits are masked out of the compare.
  function automatic logic word_mismatch(input logic [31:0] got, input logic [31:0] want);
    return (got != want);
  endfunction

endpackage

// File: rtl/tag_sysid_probe.sv
// Avalon-MM read master that reads sysid word 0 (ID) and word 1 (build
// timestamp) back to back, compares them with build-time values and keeps
// sticky pass/fail/timeout status. Launches on request or once after reset.
module tag_sysid_probe
  import tag_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        auto_q, auto_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        idm_q, idm_d;
  logic        tsm_q, tsm_d;
  logic        to_q, to_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        id_bad_s;
  logic        ts_bad_s;

  assign id_bad_s = word_mismatch(avm_readdata, EXPECTED_ID);
  assign ts_bad_s = word_mismatch(avm_readdata, EXPECTED_TS);

  // Next-state logic: launch, read sequencing, stall counting and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    auto_d  = auto_q;
    read_d  = read_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    idm_d   = idm_q;
    tsm_d   = tsm_q;
    to_d    = to_q;
    id_d    = id_q;
    ts_d    = ts_q;
    case (state_q)
      ST_IDLE: begin
        // A pending auto-start and a coincident start pulse are one launch.
        if (start || auto_q) begin
          state_d = ST_RD_ID;
          auto_d  = 1'b0;
          cnt_d   = 16'd0;
          read_d  = 1'b1;
          addr_d  = SYSID_ADDR_ID;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          idm_d   = 1'b0;
          tsm_d   = 1'b0;
          to_d    = 1'b0;
        end else begin
          read_d  = 1'b0;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        if (cnt_q == TIMEOUT_LIM) begin
          // Read was already withdrawn last edge; finish as an abort and
          // leave the captured word and its mismatch flag untouched.
          state_d = ST_DONE;
          read_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          to_d    = 1'b1;
        end else if (!avm_waitrequest) begin
          if (state_q == ST_RD_ID) begin
            id_d    = avm_readdata;
            idm_d   = id_bad_s;
            cnt_d   = 16'd0;
            addr_d  = SYSID_ADDR_TS;
            state_d = ST_RD_TS;
          end else begin
            ts_d    = avm_readdata;
            tsm_d   = ts_bad_s;
            read_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = !idm_q && !ts_bad_s;
            state_d = ST_DONE;
          end
        end else begin
          // Stalled: address and read stay put until the limit is hit.
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TIMEOUT_LIM) begin
            read_d = 1'b0;
          end else begin
            read_d = read_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      auto_q  <= AUTO_START;
      read_q  <= 1'b0;
      addr_q  <= SYSID_ADDR_ID;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      idm_q   <= 1'b0;
      tsm_q   <= 1'b0;
      to_q    <= 1'b0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      auto_q  <= auto_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      idm_q   <= idm_d;
      tsm_q   <= tsm_d;
      to_q    <= to_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = idm_q;
  assign ts_mismatch = tsm_q;
  assign timeout     = to_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_tag_sysid_probe.sv
// Bench for tag_sysid_probe: two probes (default build, and one expecting a
// different timestamp with a 4-cycle timeout and no auto-start) each talk to
// a sysid slave model with per-word waitrequest injection.
module tb_tag_sysid_probe;

  typedef struct {
    int          lat;
    logic        pass, idm, tsm, to;
    logic [31:0] idv, tsv;
  } res_t;

  typedef struct {
    int          w0, w1;
    logic [31:0] d0, d1;
    res_t        ea, eb;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] id_word = 32'h0;
  logic [31:0] ts_word = 32'h606F_A015;
  int          need_a0 = 0, need_a1 = 0, need_b0 = 0, need_b1 = 0;
  int          stall_a = 0, stall_b = 0;
  int          n_vec = 0, n_bad = 0;

  logic        addr_a, read_a, wr_a, busy_a, done_a, pass_a, idm_a, tsm_a, to_a;
  logic        addr_b, read_b, wr_b, busy_b, done_b, pass_b, idm_b, tsm_b, to_b;
  logic [31:0] rdata_a, rdata_b, idv_a, tsv_a, idv_b, tsv_b;

  always #5 clock = ~clock;

  // sysid slave: word 0 = ID, word 1 = timestamp; waitrequest for the first
  // need_* cycles of each read.
  assign rdata_a = addr_a ? ts_word : id_word;
  assign rdata_b = addr_b ? ts_word : id_word;
  assign wr_a = read_a && (stall_a < (addr_a ? need_a1 : need_a0));
  assign wr_b = read_b && (stall_b < (addr_b ? need_b1 : need_b0));

  always @(posedge clock) begin
    stall_a <= (read_a && wr_a) ? stall_a + 1 : 0;
    stall_b <= (read_b && wr_b) ? stall_b + 1 : 0;
  end

  tag_sysid_probe dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(addr_a), .avm_read(read_a), .avm_readdata(rdata_a),
    .avm_waitrequest(wr_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .id_mismatch(idm_a), .ts_mismatch(tsm_a), .timeout(to_a),
    .id_value(idv_a), .ts_value(tsv_a));

  tag_sysid_probe #(
    .EXPECTED_ID(32'h0000_0000), .EXPECTED_TS(32'h606F_A016),
    .TIMEOUT_CYCLES(4), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(addr_b), .avm_read(read_b), .avm_readdata(rdata_b),
    .avm_waitrequest(wr_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .id_mismatch(idm_b), .ts_mismatch(tsm_b), .timeout(to_b),
    .id_value(idv_b), .ts_value(tsv_b));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  function automatic res_t mk(input int lat, input logic [3:0] f, input logic [31:0] idv, input logic [31:0] tsv);
    res_t r;
    r.lat = lat; r.pass = f[3]; r.idm = f[2]; r.tsm = f[1]; r.to = f[0];
    r.idv = idv; r.tsv = tsv;
    return r;
  endfunction

  // Outcome of one check from the slave behaviour: a read stalled for at
  // least n cycles aborts; read is up n cycles, done two cycles after that.
  function automatic res_t model(input int n, input logic [31:0] exp_id, input logic [31:0] exp_ts,
                                 input int w0, input int w1, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] old_id, input logic [31:0] old_ts);
    res_t r;
    r = mk(0, 4'b0000, old_id, old_ts);
    if (w0 >= n) begin
      r.lat = n + 2; r.to = 1'b1;
    end else begin
      r.idv = d0; r.idm = (d0 != exp_id);
      if (w1 >= n) begin
        r.lat = (w0 + 1) + n + 2; r.to = 1'b1;
      end else begin
        r.lat = w0 + w1 + 3; r.tsv = d1; r.tsm = (d1 != exp_ts);
        r.pass = !r.idm && !r.tsm;
      end
    end
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t e, input logic dn, input logic ps,
                           input logic im, input logic tm, input logic tt,
                           input logic [31:0] iv, input logic [31:0] tv);
    chk({tag, ".done"}, 32'(dn), 32'd1);
    chk({tag, ".pass"}, 32'(ps), 32'(e.pass));
    chk({tag, ".id_mismatch"}, 32'(im), 32'(e.idm));
    chk({tag, ".ts_mismatch"}, 32'(tm), 32'(e.tsm));
    chk({tag, ".timeout"}, 32'(tt), 32'(e.to));
    chk({tag, ".id_value"}, iv, e.idv);
    chk({tag, ".ts_value"}, tv, e.tsv);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int last;
    need_a0 = v.w0; need_a1 = v.w1; need_b0 = v.w0; need_b1 = v.w1;
    id_word = v.d0; ts_word = v.d1;
    last = ((v.ea.lat > v.eb.lat) ? v.ea.lat : v.eb.lat) + 1;
    start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      start = 1'b0;
      if (c == v.ea.lat - 1) chk({tag, ".a.done_early"}, 32'(done_a), 32'd0);
      if (c == v.eb.lat - 1) chk({tag, ".b.done_early"}, 32'(done_b), 32'd0);
      if (c == v.ea.lat) check_res({tag, ".a"}, v.ea, done_a, pass_a, idm_a, tsm_a, to_a, idv_a, tsv_a);
      if (c == v.eb.lat) check_res({tag, ".b"}, v.eb, done_b, pass_b, idm_b, tsm_b, to_b, idv_b, tsv_b);
    end
    tick();
  endtask

  vec_t tbl[5];

  initial begin
    logic [31:0] la_id, la_ts, lb_id, lb_ts;
    int          rd_cnt;
    vec_t        v;

    tbl[0] = '{0, 0, 32'h0, 32'h606F_A015, mk(3, 4'b1000, 32'h0, 32'h606F_A015), mk(3, 4'b0010, 32'h0, 32'h606F_A015)};
    tbl[1] = '{0, 0, 32'h0, 32'h606F_A016, mk(3, 4'b0010, 32'h0, 32'h606F_A016), mk(3, 4'b1000, 32'h0, 32'h606F_A016)};
    tbl[2] = '{2, 1, 32'h1, 32'h606F_A015, mk(6, 4'b0100, 32'h1, 32'h606F_A015), mk(6, 4'b0110, 32'h1, 32'h606F_A015)};
    tbl[3] = '{4, 0, 32'h0, 32'h606F_A015, mk(7, 4'b1000, 32'h0, 32'h606F_A015), mk(6, 4'b0001, 32'h1, 32'h606F_A015)};
    tbl[4] = '{1, 5, 32'h0, 32'h606F_A016, mk(9, 4'b0010, 32'h0, 32'h606F_A016), mk(8, 4'b0001, 32'h0, 32'h606F_A015)};

    // Reset values.
    repeat (3) tick();
    chk("rst.read_a", 32'(read_a), 32'd0);
    chk("rst.busy_a", 32'(busy_a), 32'd0);
    chk("rst.done_a", 32'(done_a), 32'd0);
    chk("rst.flags_a", {28'd0, pass_a, idm_a, tsm_a, to_a}, 32'd0);
    chk("rst.idv_a", idv_a, 32'd0);
    chk("rst.tsv_a", tsv_a, 32'd0);
    chk("rst.addr_b", 32'(addr_b), 32'd0);

    // Auto-start on release: probe a runs, probe b stays idle.
    reset_n = 1'b1;
    tick();
    chk("auto.c1.read_a", 32'(read_a), 32'd1);
    chk("auto.c1.addr_a", 32'(addr_a), 32'd0);
    chk("auto.c1.busy_a", 32'(busy_a), 32'd1);
    chk("auto.c1.read_b", 32'(read_b), 32'd0);
    tick();
    chk("auto.c2.addr_a", 32'(addr_a), 32'd1);
    chk("auto.c2.read_a", 32'(read_a), 32'd1);
    tick();
    check_res("auto.a", mk(3, 4'b1000, 32'h0, 32'h606F_A015), done_a, pass_a, idm_a, tsm_a, to_a, idv_a, tsv_a);
    chk("auto.busy_b", 32'(busy_b), 32'd0);
    chk("auto.done_b", 32'(done_b), 32'd0);
    tick();

    // Directed table.
    for (int i = 0; i < 5; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Randomised runs against the model.
    la_id = tbl[4].ea.idv; la_ts = tbl[4].ea.tsv;
    lb_id = tbl[4].eb.idv; lb_ts = tbl[4].eb.tsv;
    for (int i = 0; i < 30; i++) begin
      v.w0 = int'($urandom_range(0, 6));
      v.w1 = int'($urandom_range(0, 6));
      v.d0 = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      case ($urandom_range(0, 2))
        0: v.d1 = 32'h606F_A015;
        1: v.d1 = 32'h606F_A016;
        default: v.d1 = $urandom;
      endcase
      v.ea = model(255, 32'h0, 32'h606F_A015, v.w0, v.w1, v.d0, v.d1, la_id, la_ts);
      v.eb = model(4, 32'h0, 32'h606F_A016, v.w0, v.w1, v.d0, v.d1, lb_id, lb_ts);
      run_vec($sformatf("rnd%0d", i), v);
      la_id = v.ea.idv; la_ts = v.ea.tsv; lb_id = v.eb.idv; lb_ts = v.eb.tsv;
    end

    // Three stalls per read, start re-pulsed while busy and in DONE.
    need_a0 = 3; need_a1 = 3; need_b0 = 3; need_b1 = 3;
    id_word = 32'h0; ts_word = 32'h606F_A015;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = (c == 3 || c == 9) ? 1'b1 : 1'b0;
      if (c <= 3) chk($sformatf("stall.c%0d.addr0", c), {30'd0, read_a, addr_a}, 32'd2);
      if (c >= 5 && c <= 7) chk($sformatf("stall.c%0d.addr1", c), {30'd0, read_a, addr_a}, 32'd3);
      if (c <= 8) chk($sformatf("stall.c%0d.busy", c), 32'(busy_a), 32'd1);
      if (c == 8) chk("stall.done_early", 32'(done_a), 32'd0);
      if (c >= 9) check_res($sformatf("stall.c%0d", c), mk(9, 4'b1000, 32'h0, 32'h606F_A015),
                            done_a, pass_a, idm_a, tsm_a, to_a, idv_a, tsv_a);
      if (c >= 10) chk($sformatf("norelaunch.c%0d.busy_a", c), 32'(busy_a), 32'd0);
      if (c >= 10) chk($sformatf("norelaunch.c%0d.busy_b", c), 32'(busy_b), 32'd0);
    end
    lb_id = idv_b; lb_ts = tsv_b;
    chk("stall.b.tsm", 32'(tsm_b), 32'd1);

    // Stuck waitrequest on probe b: read for 4 cycles, then abort.
    need_a0 = 0; need_a1 = 0; need_b0 = 1000; need_b1 = 1000;
    id_word = 32'h1234_5678;
    rd_cnt = 0;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      if (read_b) rd_cnt++;
      if (c == 5) chk("to.done_early", 32'(done_b), 32'd0);
      if (c == 6) check_res("to.b", mk(6, 4'b0001, 32'h0, 32'h606F_A015), done_b, pass_b, idm_b, tsm_b, to_b, idv_b, tsv_b);
    end
    chk("to.read_cycles", 32'(rd_cnt), 32'd4);
    chk("to.idv_kept", idv_b, lb_id);

    // Reset pulse during RD_TS, then auto-start reruns probe a.
    need_b0 = 0; need_b1 = 0;
    id_word = 32'h0; ts_word = 32'h606F_A015;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rstmid.in_rdts", {30'd0, read_a, addr_a}, 32'd3);
    reset_n = 1'b0;
    tick();
    chk("rstmid.read_a", 32'(read_a), 32'd0);
    chk("rstmid.busy_a", 32'(busy_a), 32'd0);
    chk("rstmid.flags_a", {27'd0, done_a, pass_a, idm_a, tsm_a, to_a}, 32'd0);
    chk("rstmid.idv_a", idv_a, 32'd0);
    chk("rstmid.read_b", 32'(read_b), 32'd0);
    chk("rstmid.flags_b", {27'd0, done_b, pass_b, idm_b, tsm_b, to_b}, 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check_res("rstmid.rerun.a", mk(3, 4'b1000, 32'h0, 32'h606F_A015), done_a, pass_a, idm_a, tsm_a, to_a, idv_a, tsv_a);
    chk("rstmid.rerun.busy_b", 32'(busy_b), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
